rv32i_lsu_ctrl: RTL and testbench
=================================

Name: rv32i_lsu_ctrl

Overview:
- Load/store sequencer between the execute stage of the 3-stage RV32I pipeline and the data-memory bus.
- Accepts one memory op per handshake, using the control fields mem_read, mem_write and mem_funct3.
- Generates byte enables and word-aligned bus requests, and stalls the pipeline while an access is outstanding.
- Returns sign- or zero-extended load data for writeback, and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles from bus_req assertion to bus_rvalid before the access is aborted with err_timeout.
- CNT_W, 7: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents a memory op
- req_ready  out  1  controller can accept an op this cycle
- req_read  in  1  load (control_t.mem_read)
- req_write  in  1  store (control_t.mem_write)
- req_funct3  in  3  size/sign (control_t.mem_funct3)
- req_addr  in  32  effective byte address
- req_wdata  in  32  store data, unshifted
- req_rd  in  5  load destination register
- flush  in  1  squash the current op (branch/jump redirect)
- stall  out  1  hold the pipeline
- wb_valid  out  1  one-cycle load-result strobe
- wb_rd  out  5  destination register
- wb_data  out  32  extended load data
- err_misalign  out  1  one-cycle strobe, misaligned request rejected
- err_timeout  out  1  one-cycle strobe, bus timeout
- err_addr  out  32  faulting byte address
- bus_req  out  1  bus request
- bus_we  out  1  write
- bus_addr  out  32  word address ({req_addr[31:2],2'b00})
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-shifted store data
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  response/ack, for loads and stores
- bus_rdata  in  32  read word

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0. bus_req, stall, wb_valid, err_* = 0. bus_addr, bus_wdata, bus_be, err_addr, wb_data, wb_rd = 0.
- States:
  - IDLE: req_ready=1.
  - REQ: bus_req=1 until bus_gnt.
  - WAIT: awaiting bus_rvalid.
- Accept: req_valid & req_ready & (req_read|req_write).
  - req_read & req_write together is illegal; treat the op as a load.
  - req_valid with neither read nor write is ignored.
- Alignment check at accept:
  - Half (funct3[1:0]=01) requires addr[0]=0.
  - Word (10) requires addr[1:0]=0.
  - funct3 11 is treated as misaligned.
  - On failure: err_misalign and err_addr set the next cycle, no bus access, stay in IDLE.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<addr[1:0].
  - Word: 4'b1111.
- Store data: wdata replicated into lanes (byte x4, half x2). All bus_* outputs are registered and held stable from REQ entry until bus_gnt.
- IDLE->REQ on accept. REQ->WAIT on bus_gnt. WAIT->IDLE on bus_rvalid.
  - bus_gnt and bus_rvalid in the same REQ cycle is legal: go directly to IDLE.
- stall:
  - Combinational, =1 whenever state!=IDLE.
  - Also =1 in the accept cycle, so the op is held.
  - Minimum load/store latency: 2 cycles (accept, then gnt+rvalid together). wb_valid is asserted the cycle after rvalid.
- Load data:
  - Lane select by the latched addr[1:0].
  - funct3[2]=0 sign-extends, =1 zero-extends (LB/LH/LW/LBU/LHU).
  - wb_valid is a single-cycle pulse; stores never assert wb_valid.
  - A load to rd=0 still pulses wb_valid with wb_rd=0; the register file drops it.
- Timeout:
  - Counter clears on accept and increments each cycle in REQ or WAIT.
  - Reaching TIMEOUT_CYCLES with no rvalid: err_timeout pulse with err_addr, deassert bus_req, return to IDLE, no wb_valid.
  - A late bus_rvalid arriving in IDLE is ignored.
- Flush:
  - In REQ before gnt: drop bus_req next cycle and go to IDLE, no bus side effect.
  - Flush in the same cycle as gnt: the bus has committed, go to WAIT.
  - In WAIT: complete the bus transaction but suppress wb_valid.
  - In the accept cycle: the op is not accepted.
- Mid-operation reset: immediate return to reset values, outstanding bus response discarded.

Decomposition:
- Add to rv32i_pkg:
  - lsu_state_e {LSU_IDLE, LSU_REQ, LSU_WAIT}.
  - Funct3 size constants MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10.
  - Function lsu_be(funct3, addr_lo) returning byte enables.
- Sub-module rv32i_load_align (combinational): rdata, addr_lo, funct3 -> extended wb_data. It is reused by any future instruction-fetch or atomic path.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF; gnt and rvalid both in cycle 1 -> bus_be=1111, bus_addr=0x100, stall for 2 cycles, no wb_valid.
- LB addr 0x203, rdata 0x80FF_FF7F -> bus_be=1000, wb_data=0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x202 -> 0xFFFF80FF.
- SH addr 0x101 -> err_misalign pulse, err_addr=0x101, bus_req never asserted, stall released next cycle.
- LW with gnt held off 3 cycles -> bus_addr/be stable for 3 cycles. rvalid delayed 5 cycles -> single wb_valid pulse, correct rd.
- LW, rvalid never arrives, TIMEOUT_CYCLES=64 -> err_timeout at cycle 64 after accept, bus_req low, IDLE.
- Flush checks:
  - Flush in REQ before gnt -> no gnt needed, no wb_valid.
  - Flush in WAIT -> rvalid consumed, wb_valid suppressed.
  - rst_n pulse in WAIT -> all outputs at reset values.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and helpers for the RV32I core.
//   lsu_state_e     - load/store sequencer states
//   MEM_B/H/W       - mem_funct3[1:0] access-size encodings
//   lsu_be()        - byte enables for a size and byte offset
//   lsu_misaligned()- alignment check for a size and byte offset
//   lsu_wdata()     - store data replicated into all byte lanes
package rv32i_pkg;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_REQ,
      LSU_WAIT
   } lsu_state_e;

   localparam logic [1:0] MEM_B = 2'b00;
   localparam logic [1:0] MEM_H = 2'b01;
   localparam logic [1:0] MEM_W = 2'b10;

   function automatic logic [3:0] lsu_be(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
      logic [3:0] be;
      case (funct3[1:0])
         MEM_B:   be = 4'b0001 << addr_lo;
         MEM_H:   be = 4'b0011 << addr_lo;
         MEM_W:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic lsu_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
      logic bad;
      case (funct3[1:0])
         MEM_B:   bad = 1'b0;
         MEM_H:   bad = addr_lo[0];
         MEM_W:   bad = |addr_lo;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [31:0] lsu_wdata(input logic [2:0]  funct3,
                                             input logic [31:0] wdata);
      logic [31:0] w;
      case (funct3[1:0])
         MEM_B:   w = {4{wdata[7:0]}};
         MEM_H:   w = {2{wdata[15:0]}};
         default: w = wdata;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// rv32i_load_align: combinational load-data lane select and extension.
//   rdata   in  32  raw bus read word
//   addr_lo in  2   byte offset of the access
//   funct3  in  3   size (bits 1:0) and unsigned flag (bit 2)
//   wb_data out 32  sign- or zero-extended result (LB/LH/LW/LBU/LHU)
module rv32i_load_align
   import rv32i_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] wb_data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic        sext;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_v = rdata[7:0];
         2'd1:    byte_v = rdata[15:8];
         2'd2:    byte_v = rdata[23:16];
         default: byte_v = rdata[31:24];
      endcase
      half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      sext   = ~funct3[2];
      case (funct3[1:0])
         MEM_B:   wb_data = {{24{sext & byte_v[7]}}, byte_v};
         MEM_H:   wb_data = {{16{sext & half_v[15]}}, half_v};
         default: wb_data = rdata;
      endcase
   end

endmodule

// File: rtl/rv32i_lsu_ctrl.sv
// rv32i_lsu_ctrl: load/store sequencer between execute and the data bus.
//   req_*      execute-stage op handshake (valid/ready, read, write,
//              funct3, byte address, unshifted store data, rd)
//   flush      squash the current op
//   stall      hold the pipeline while an op is accepted or in flight
//   wb_*       one-cycle load writeback strobe, rd and extended data
//   err_*      misalign / timeout strobes and faulting byte address
//   bus_*      registered word-aligned request (req/we/addr/be/wdata),
//              gnt accepts it, rvalid/rdata complete it
module rv32i_lsu_ctrl
   import rv32i_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   input  logic        flush,
   output logic        stall,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        err_misalign,
   output logic        err_timeout,
   output logic [31:0] err_addr,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   lsu_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [31:0]       bus_addr_q, bus_addr_d;
   logic [3:0]        bus_be_q, bus_be_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic [4:0]        rd_q, rd_d;
   logic              kill_q, kill_d;
   logic              wb_valid_q, wb_valid_d;
   logic [4:0]        wb_rd_q, wb_rd_d;
   logic [31:0]       wb_data_q, wb_data_d;
   logic              err_mis_q, err_mis_d;
   logic              err_to_q, err_to_d;
   logic [31:0]       err_addr_q, err_addr_d;

   logic              accept;
   logic              timeout_hit;
   logic [31:0]       align_data;

   rv32i_load_align u_align (
      .rdata   (bus_rdata),
      .addr_lo (addr_lo_q),
      .funct3  (funct3_q),
      .wb_data (align_data)
   );

   assign req_ready   = (state_q == LSU_IDLE);
   assign accept      = req_valid & req_ready & (req_read | req_write) & ~flush;
   // Last allowed bus cycle: the counter would reach TIMEOUT_CYCLES next.
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign stall       = (state_q != LSU_IDLE) | accept;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      funct3_d    = funct3_q;
      addr_lo_d   = addr_lo_q;
      rd_d        = rd_q;
      kill_d      = kill_q;
      wb_valid_d  = 1'b0;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      err_mis_d   = 1'b0;
      err_to_d    = 1'b0;
      err_addr_d  = err_addr_q;

      case (state_q)
         LSU_IDLE: begin
            if (accept) begin
               cnt_d = '0;
               if (lsu_misaligned(req_funct3, req_addr[1:0])) begin
                  err_mis_d  = 1'b1;
                  err_addr_d = req_addr;
               end else begin
                  state_d     = LSU_REQ;
                  bus_req_d   = 1'b1;
                  // Simultaneous read+write is treated as a load.
                  bus_we_d    = req_write & ~req_read;
                  bus_addr_d  = {req_addr[31:2], 2'b00};
                  bus_be_d    = lsu_be(req_funct3, req_addr[1:0]);
                  bus_wdata_d = lsu_wdata(req_funct3, req_wdata);
                  funct3_d    = req_funct3;
                  addr_lo_d   = req_addr[1:0];
                  rd_d        = req_rd;
                  kill_d      = 1'b0;
               end
            end
         end

         LSU_REQ: begin
            cnt_d = cnt_q + 1'b1;
            if (bus_gnt) begin
               // Bus has committed; a flush here only suppresses writeback.
               bus_req_d = 1'b0;
               kill_d    = kill_q | flush;
               if (bus_rvalid) begin
                  state_d = LSU_IDLE;
                  if (~bus_we_q & ~(kill_q | flush)) begin
                     wb_valid_d = 1'b1;
                     wb_rd_d    = rd_q;
                     wb_data_d  = align_data;
                  end
               end else begin
                  state_d = LSU_WAIT;
               end
            end else if (flush) begin
               bus_req_d = 1'b0;
               state_d   = LSU_IDLE;
            end else if (timeout_hit) begin
               bus_req_d  = 1'b0;
               state_d    = LSU_IDLE;
               err_to_d   = 1'b1;
               err_addr_d = {bus_addr_q[31:2], addr_lo_q};
            end
         end

         LSU_WAIT: begin
            cnt_d  = cnt_q + 1'b1;
            kill_d = kill_q | flush;
            if (bus_rvalid) begin
               state_d = LSU_IDLE;
               if (~bus_we_q & ~(kill_q | flush)) begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = rd_q;
                  wb_data_d  = align_data;
               end
            end else if (timeout_hit) begin
               state_d    = LSU_IDLE;
               err_to_d   = 1'b1;
               err_addr_d = {bus_addr_q[31:2], addr_lo_q};
            end
         end

         default: state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LSU_IDLE;
         cnt_q       <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= '0;
         bus_wdata_q <= '0;
         funct3_q    <= '0;
         addr_lo_q   <= '0;
         rd_q        <= '0;
         kill_q      <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         err_mis_q   <= 1'b0;
         err_to_q    <= 1'b0;
         err_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         funct3_q    <= funct3_d;
         addr_lo_q   <= addr_lo_d;
         rd_q        <= rd_d;
         kill_q      <= kill_d;
         wb_valid_q  <= wb_valid_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         err_mis_q   <= err_mis_d;
         err_to_q    <= err_to_d;
         err_addr_q  <= err_addr_d;
      end
   end

   assign bus_req      = bus_req_q;
   assign bus_we       = bus_we_q;
   assign bus_addr     = bus_addr_q;
   assign bus_be       = bus_be_q;
   assign bus_wdata    = bus_wdata_q;
   assign wb_valid     = wb_valid_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign err_misalign = err_mis_q;
   assign err_timeout  = err_to_q;
   assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_rv32i_lsu_ctrl.sv
module tb_rv32i_lsu_ctrl;

   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [4:0]  req_rd = '0;
   logic        flush = 1'b0;
   logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
   logic [31:0] bus_rdata = '0;
   logic        req_ready, stall, wb_valid, err_misalign, err_timeout;
   logic        bus_req, bus_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, err_addr, bus_addr, bus_wdata;
   logic [3:0]  bus_be;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rv32i_lsu_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_read(req_read), .req_write(req_write), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .flush(flush), .stall(stall),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .err_misalign(err_misalign), .err_timeout(err_timeout), .err_addr(err_addr),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata)
   );

   // ---------------- reference model (byte-level arithmetic) ----------------
   function automatic int unsigned m_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit m_misal(input logic [2:0] f3, input logic [31:0] a);
      return (f3[1:0] == 2'b11) || ((a % m_size(f3)) != 0);
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      int unsigned mask;
      mask = (1 << m_size(f3)) - 1;
      return 4'((mask << (a % 4)) & 15);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r;
      r = 0;
      for (int i = 0; i < 4; i++)
         r = r | (((wd >> (8 * (i % m_size(f3)))) & 32'hFF) << (8 * i));
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] rdat);
      int unsigned bits;
      logic [31:0] mask, v;
      if (m_size(f3) >= 4) return rdat;
      bits = 8 * m_size(f3);
      mask = (32'h1 << bits) - 1;
      v = (rdat >> (8 * (a % 4))) & mask;
      if (!f3[2] && v[bits-1]) v = v | ~mask;
      return v;
   endfunction

   // ---------------- generic op driver (observations only) ----------------
   logic        o_stall_acc, o_we, o_unstable;
   int          o_stall_cyc, o_req_cyc, o_wb_cnt, o_mis;
   logic [3:0]  o_be;
   logic [31:0] o_addr, o_wdata, o_wb_data, o_err_addr;
   logic [4:0]  o_wb_rd;

   task automatic run_op(input logic rdv, input logic wrv, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdi,
                         input int gd, input int rvd, input logic [31:0] rdat);
      bit granted;
      int reqc, waitc;
      o_stall_cyc = 0; o_req_cyc = 0; o_wb_cnt = 0; o_mis = 0; o_unstable = 0;
      o_be = '0; o_addr = '0; o_wdata = '0; o_we = 0; o_wb_data = '0; o_wb_rd = '0;
      o_err_addr = '0;
      granted = 0; reqc = 0; waitc = 0;
      @(negedge clk);
      req_valid = 1; req_read = rdv; req_write = wrv; req_funct3 = f3;
      req_addr = a; req_wdata = wd; req_rd = rdi;
      #1;
      o_stall_acc = stall;
      if (stall) o_stall_cyc = 1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         req_valid = 0; bus_gnt = 0; bus_rvalid = 0;
         #1;
         if (err_misalign) begin o_mis++; o_err_addr = err_addr; end
         if (wb_valid) begin o_wb_cnt++; o_wb_data = wb_data; o_wb_rd = wb_rd; end
         if (!stall) break;
         o_stall_cyc++;
         if (bus_req) begin
            o_req_cyc++;
            if (o_req_cyc == 1) begin
               o_be = bus_be; o_addr = bus_addr; o_wdata = bus_wdata; o_we = bus_we;
            end else if (o_be !== bus_be || o_addr !== bus_addr ||
                         o_wdata !== bus_wdata || o_we !== bus_we) begin
               o_unstable = 1;
            end
         end
         if (!granted) begin
            if (bus_req && reqc == gd) begin
               bus_gnt = 1; granted = 1; waitc = 1;
               if (rvd == 0) begin bus_rvalid = 1; bus_rdata = rdat; end
            end
            reqc++;
         end else begin
            if (rvd > 0 && waitc == rvd) begin bus_rvalid = 1; bus_rdata = rdat; end
            waitc++;
         end
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); #1;
         if (err_misalign) o_mis++;
         if (wb_valid) o_wb_cnt++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [142:0] obs;
      #2 rst_n = 0;
      #1;
      obs = {stall, bus_req, wb_valid, err_misalign, err_timeout, bus_we, bus_addr,
             bus_wdata, bus_be, err_addr, wb_data, wb_rd};
      n_cmp++;
      if (obs !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", obs); end
      n_cmp++;
      if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_store_word();
      run_op(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 32'h0);
      n_cmp++; if (o_be !== 4'b1111) begin n_bad++; $display("FAIL sw_be: got %b want 1111", o_be); end
      n_cmp++; if (o_addr !== 32'h100) begin n_bad++; $display("FAIL sw_addr: got %h want 100", o_addr); end
      n_cmp++; if (o_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_wdata: got %h want deadbeef", o_wdata); end
      n_cmp++; if (o_we !== 1'b1) begin n_bad++; $display("FAIL sw_we: got %b want 1", o_we); end
      n_cmp++; if (o_stall_cyc != 2) begin n_bad++; $display("FAIL sw_stall: got %0d want 2", o_stall_cyc); end
      n_cmp++; if (o_wb_cnt != 0) begin n_bad++; $display("FAIL sw_no_wb: got %0d want 0", o_wb_cnt); end
   endtask

   task automatic test_load_ext();
      run_op(1, 0, 3'b000, 32'h203, 32'h0, 5'd7, 0, 0, 32'h80FF_FF7F);
      n_cmp++; if (o_be !== 4'b1000) begin n_bad++; $display("FAIL lb_be: got %b want 1000", o_be); end
      n_cmp++; if (o_addr !== 32'h200) begin n_bad++; $display("FAIL lb_addr: got %h want 200", o_addr); end
      n_cmp++; if (o_wb_cnt != 1 || o_wb_data !== 32'hFFFFFF80)
         begin n_bad++; $display("FAIL lb_data: got %0d/%h want 1/ffffff80", o_wb_cnt, o_wb_data); end
      n_cmp++; if (o_wb_rd !== 5'd7) begin n_bad++; $display("FAIL lb_rd: got %0d want 7", o_wb_rd); end
      run_op(1, 0, 3'b100, 32'h203, 32'h0, 5'd8, 0, 0, 32'h80FF_FF7F);
      n_cmp++; if (o_wb_data !== 32'h00000080) begin n_bad++; $display("FAIL lbu_data: got %h want 00000080", o_wb_data); end
      run_op(1, 0, 3'b001, 32'h202, 32'h0, 5'd9, 0, 0, 32'h80FF_FF7F);
      n_cmp++; if (o_wb_data !== 32'hFFFF80FF) begin n_bad++; $display("FAIL lh_data: got %h want ffff80ff", o_wb_data); end
      n_cmp++; if (o_be !== 4'b1100) begin n_bad++; $display("FAIL lh_be: got %b want 1100", o_be); end
   endtask

   task automatic test_misalign();
      run_op(0, 1, 3'b001, 32'h101, 32'h1234, 5'd0, 0, 0, 32'h0);
      n_cmp++; if (o_mis != 1) begin n_bad++; $display("FAIL sh_mis_pulse: got %0d want 1", o_mis); end
      n_cmp++; if (o_err_addr !== 32'h101) begin n_bad++; $display("FAIL sh_mis_addr: got %h want 101", o_err_addr); end
      n_cmp++; if (o_req_cyc != 0) begin n_bad++; $display("FAIL sh_mis_noreq: got %0d want 0", o_req_cyc); end
      n_cmp++; if (o_stall_cyc != 1) begin n_bad++; $display("FAIL sh_mis_stall: got %0d want 1", o_stall_cyc); end
      run_op(1, 0, 3'b011, 32'h40, 32'h0, 5'd2, 0, 0, 32'h0);
      n_cmp++; if (o_mis != 1 || o_req_cyc != 0 || o_wb_cnt != 0)
         begin n_bad++; $display("FAIL f3_11_mis: got mis=%0d req=%0d wb=%0d want 1/0/0", o_mis, o_req_cyc, o_wb_cnt); end
   endtask

   task automatic test_gnt_delay();
      run_op(1, 0, 3'b010, 32'h344, 32'h0, 5'd13, 3, 5, 32'hCAFE_0123);
      n_cmp++; if (o_req_cyc != 4) begin n_bad++; $display("FAIL gd_req_cycles: got %0d want 4", o_req_cyc); end
      n_cmp++; if (o_unstable !== 1'b0) begin n_bad++; $display("FAIL gd_stable: got %b want 0", o_unstable); end
      n_cmp++; if (o_addr !== 32'h344 || o_be !== 4'hF) begin n_bad++; $display("FAIL gd_addr_be: got %h/%h want 344/f", o_addr, o_be); end
      n_cmp++; if (o_stall_cyc != 10) begin n_bad++; $display("FAIL gd_stall: got %0d want 10", o_stall_cyc); end
      n_cmp++; if (o_wb_cnt != 1 || o_wb_rd !== 5'd13 || o_wb_data !== 32'hCAFE0123)
         begin n_bad++; $display("FAIL gd_wb: got %0d/%0d/%h want 1/13/cafe0123", o_wb_cnt, o_wb_rd, o_wb_data); end
   endtask

   task automatic test_timeout();
      int t_at, req_hi, wbc;
      logic t_req, t_stall;
      logic [31:0] t_addr;
      t_at = -1; req_hi = 0; wbc = 0; t_req = 1; t_stall = 1; t_addr = '0;
      @(negedge clk);
      req_valid = 1; req_read = 1; req_write = 0; req_funct3 = 3'b010;
      req_addr = 32'h400; req_rd = 5'd3;
      @(negedge clk);
      req_valid = 0;
      for (int k = 1; k < 100; k++) begin
         #1;
         if (wb_valid) wbc++;
         if (err_timeout) begin
            t_at = k; t_req = bus_req; t_stall = stall; t_addr = err_addr; break;
         end
         if (bus_req) req_hi++;
         @(negedge clk);
      end
      n_cmp++; if (t_at != TO + 1) begin n_bad++; $display("FAIL to_cycle: got %0d want %0d", t_at, TO + 1); end
      n_cmp++; if (req_hi != TO) begin n_bad++; $display("FAIL to_req_cycles: got %0d want %0d", req_hi, TO); end
      n_cmp++; if (t_req !== 1'b0 || t_stall !== 1'b0)
         begin n_bad++; $display("FAIL to_idle: got req=%b stall=%b want 0/0", t_req, t_stall); end
      n_cmp++; if (t_addr !== 32'h400) begin n_bad++; $display("FAIL to_addr: got %h want 400", t_addr); end
      // late response in IDLE must be ignored
      @(negedge clk); bus_rvalid = 1; bus_rdata = 32'h5555_5555;
      @(negedge clk); bus_rvalid = 0;
      for (int k = 0; k < 2; k++) begin
         #1; if (wb_valid || stall) wbc++;
         @(negedge clk);
      end
      n_cmp++; if (wbc != 0) begin n_bad++; $display("FAIL to_late_rvalid: got %0d want 0", wbc); end
   endtask

   task automatic start_lw(input logic [31:0] a);
      @(negedge clk);
      req_valid = 1; req_read = 1; req_write = 0; req_funct3 = 3'b010;
      req_addr = a; req_rd = 5'd21;
      @(negedge clk);
      req_valid = 0;
   endtask

   task automatic test_flush();
      int wbc;
      // flush in REQ before grant
      start_lw(32'h500);
      #1; flush = 1;
      @(negedge clk); flush = 0; #1;
      n_cmp++; if (bus_req !== 1'b0 || stall !== 1'b0)
         begin n_bad++; $display("FAIL fl_req: got req=%b stall=%b want 0/0", bus_req, stall); end
      wbc = 0;
      for (int k = 0; k < 2; k++) begin @(negedge clk); #1; if (wb_valid) wbc++; end
      n_cmp++; if (wbc != 0) begin n_bad++; $display("FAIL fl_req_wb: got %0d want 0", wbc); end
      // flush in accept cycle
      @(negedge clk);
      req_valid = 1; req_read = 1; req_funct3 = 3'b010; req_addr = 32'h504; flush = 1;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fl_acc_stall: got %b want 0", stall); end
      @(negedge clk); req_valid = 0; flush = 0; #1;
      n_cmp++; if (bus_req !== 1'b0 || stall !== 1'b0)
         begin n_bad++; $display("FAIL fl_acc_noop: got req=%b stall=%b want 0/0", bus_req, stall); end
      // flush together with grant
      start_lw(32'h508);
      bus_gnt = 1; flush = 1;
      @(negedge clk); bus_gnt = 0; flush = 0; #1;
      n_cmp++; if (stall !== 1'b1 || bus_req !== 1'b0)
         begin n_bad++; $display("FAIL fl_gnt_wait: got stall=%b req=%b want 1/0", stall, bus_req); end
      bus_rvalid = 1; bus_rdata = 32'h1111_2222;
      @(negedge clk); bus_rvalid = 0;
      wbc = 0;
      for (int k = 0; k < 2; k++) begin #1; if (wb_valid || stall) wbc++; @(negedge clk); end
      n_cmp++; if (wbc != 0) begin n_bad++; $display("FAIL fl_gnt_wb: got %0d want 0", wbc); end
      // flush in WAIT
      start_lw(32'h50C);
      bus_gnt = 1;
      @(negedge clk); bus_gnt = 0; flush = 1;
      @(negedge clk); flush = 0; #1;
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL fl_wait_hold: got %b want 1", stall); end
      bus_rvalid = 1; bus_rdata = 32'h3333_4444;
      @(negedge clk); bus_rvalid = 0;
      wbc = 0;
      for (int k = 0; k < 2; k++) begin #1; if (wb_valid || stall) wbc++; @(negedge clk); end
      n_cmp++; if (wbc != 0) begin n_bad++; $display("FAIL fl_wait_wb: got %0d want 0", wbc); end
      // op with neither read nor write is ignored
      req_valid = 1; req_read = 0; req_write = 0; #1;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ignore_stall: got %b want 0", stall); end
      @(negedge clk); req_valid = 0; #1;
      n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL ignore_req: got %b want 0", bus_req); end
   endtask

   task automatic test_reset_mid();
      logic [142:0] obs;
      int wbc;
      run_op(1, 0, 3'b000, 32'h601, 32'h0, 5'd4, 0, 0, 32'h0000_AB00);
      start_lw(32'h600);
      bus_gnt = 1;
      @(negedge clk); bus_gnt = 0;
      rst_n = 0; #1;
      obs = {stall, bus_req, wb_valid, err_misalign, err_timeout, bus_we, bus_addr,
             bus_wdata, bus_be, err_addr, wb_data, wb_rd};
      n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL rst_mid: got %h want 0", obs); end
      @(negedge clk); rst_n = 1; bus_rvalid = 1; bus_rdata = 32'h7777_7777;
      @(negedge clk); bus_rvalid = 0;
      wbc = 0;
      for (int k = 0; k < 2; k++) begin #1; if (wb_valid || stall) wbc++; @(negedge clk); end
      n_cmp++; if (wbc != 0) begin n_bad++; $display("FAIL rst_mid_resp: got %0d want 0", wbc); end
   endtask

   task automatic test_random();
      logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      logic [2:0] f3;
      logic rdv, wrv;
      logic [31:0] a, wd, rdat;
      logic [4:0] rdi;
      int gd, rvd, bad_here;
      bit is_ld;
      for (int n = 0; n < 60; n++) begin
         rdv = 1'($urandom_range(0, 1));
         wrv = rdv ? ($urandom_range(0, 7) == 0) : 1'b1;
         is_ld = rdv;
         f3 = is_ld ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
         if ($urandom_range(0, 15) == 0) f3 = 3'b011;
         a = $urandom;
         if ($urandom_range(0, 3) != 0 && f3[1:0] != 2'b11)
            a = a & ~(32'(m_size(f3)) - 1);
         wd = $urandom; rdat = $urandom; rdi = 5'($urandom_range(0, 31));
         gd = $urandom_range(0, 3); rvd = $urandom_range(0, 4);
         run_op(rdv, wrv, f3, a, wd, rdi, gd, rvd, rdat);
         bad_here = 0;
         n_cmp++;
         if (o_stall_acc !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_acc_stall: got %b want 1", n, o_stall_acc); end
         if (m_misal(f3, a)) begin
            n_cmp++;
            if (o_mis != 1 || o_err_addr !== a || o_req_cyc != 0 || o_wb_cnt != 0) begin
               n_bad++;
               $display("FAIL rnd%0d_mis: got mis=%0d addr=%h req=%0d wb=%0d want 1/%h/0/0",
                        n, o_mis, o_err_addr, o_req_cyc, o_wb_cnt, a);
            end
         end else begin
            n_cmp++;
            if (o_be !== m_be(f3, a) || o_addr !== (a & 32'hFFFF_FFFC) || o_we !== (wrv & ~rdv)) begin
               n_bad++;
               $display("FAIL rnd%0d_bus: got be=%b addr=%h we=%b want %b/%h/%b",
                        n, o_be, o_addr, o_we, m_be(f3, a), a & 32'hFFFF_FFFC, wrv & ~rdv);
            end
            n_cmp++;
            if (o_wdata !== m_wdata(f3, wd)) begin
               n_bad++; $display("FAIL rnd%0d_wdata: got %h want %h", n, o_wdata, m_wdata(f3, wd));
            end
            n_cmp++;
            if (o_stall_cyc != 2 + gd + rvd || o_unstable !== 1'b0) begin
               n_bad++;
               $display("FAIL rnd%0d_timing: got stall=%0d unstable=%b want %0d/0",
                        n, o_stall_cyc, o_unstable, 2 + gd + rvd);
            end
            n_cmp++;
            if (o_wb_cnt != (is_ld ? 1 : 0)) begin
               n_bad++; $display("FAIL rnd%0d_wb_cnt: got %0d want %0d", n, o_wb_cnt, is_ld ? 1 : 0);
            end
            if (is_ld) begin
               n_cmp++;
               if (o_wb_data !== m_load(f3, a, rdat) || o_wb_rd !== rdi) begin
                  n_bad++;
                  $display("FAIL rnd%0d_load: got %h rd=%0d want %h rd=%0d",
                           n, o_wb_data, o_wb_rd, m_load(f3, a, rdat), rdi);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_load_ext();
      test_misalign();
      test_gnt_delay();
      test_timeout();
      test_flush();
      test_reset_mid();
      test_random();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "bench time limit");
   end

endmodule
